mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Serialises icache refills and dcache line accesses onto one memory port; MEM_ARBITER_STATS_EN adds grant/conflict counters.
// Latency: grant in IDLE, LATENCY BUSY cycles, one-cycle ack in RESP; next grant LATENCY+2 cycles after the previous one.
// Backpressure: each req is held until its ack; the losing port waits, and ties alternate so neither port starves.
module mem_arbiter #(
   parameter int WIDTH   = 128,
   parameter int ADDR    = 32,
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ic_req,
   input  logic [ADDR-1:0]  ic_addr,
   output logic             ic_ack,
   output logic [WIDTH-1:0] ic_rdata,
   input  logic             dc_req,
   input  logic             dc_write,
   input  logic [ADDR-1:0]  dc_addr,
   input  logic [WIDTH-1:0] dc_wdata,
   output logic             dc_ack,
   output logic [WIDTH-1:0] dc_rdata,
   output logic [ADDR-1:0]  mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_memread,
   output logic             mem_memwrite,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [31:0]      stat_ic_grants,
   output logic [31:0]      stat_dc_grants,
   output logic [31:0]      stat_conflicts
);

   if (LATENCY < 1) begin : g_bad_latency
      $error("mem_arbiter: LATENCY must be at least 1");
   end

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   typedef struct packed {
      logic             write;
      logic [ADDR-1:0]  addr;
      logic [WIDTH-1:0] wdata;
   } acc_t;

   state_t        state, state_nxt;
   acc_t          acc;
   logic [CW-1:0] cnt;
   logic          owner;       // 0 = icache, 1 = dcache
   logic          last_grant;
   logic          grant_vld;
   logic          grant_dc;
   logic          busy_last;

   // Tie goes to the port that did not win last time.
   assign grant_vld = (state == S_IDLE) && (ic_req || dc_req);
   assign grant_dc  = dc_req && (!ic_req || !last_grant);
   assign busy_last = (state == S_BUSY) && (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_vld) state_nxt = S_BUSY;
         S_BUSY:  if (cnt == '0) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory strobes decode from state so a mid-access reset kills them at once.
   always_comb begin
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_memread  = 1'b0;
      mem_memwrite = 1'b0;
      if (state == S_BUSY) begin
         mem_addr     = acc.addr;
         mem_wdata    = acc.wdata;
         mem_memread  = !acc.write;
         mem_memwrite = acc.write && (cnt == '0);
      end
      ic_ack = (state == S_RESP) && !owner;
      dc_ack = (state == S_RESP) && owner;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc        <= '0;
         cnt        <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         ic_rdata   <= '0;
         dc_rdata   <= '0;
      end else begin
         if (grant_vld) begin
            owner      <= grant_dc;
            last_grant <= grant_dc;
            acc.write  <= grant_dc && dc_write;
            acc.addr   <= grant_dc ? dc_addr : ic_addr;
            acc.wdata  <= grant_dc ? dc_wdata : '0;
            cnt        <= CW'(LATENCY - 1);
         end else if ((state == S_BUSY) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
         if (busy_last && !acc.write) begin
            if (owner) dc_rdata <= mem_rdata;
            else       ic_rdata <= mem_rdata;
         end
      end
   end

`ifdef MEM_ARBITER_STATS_EN
   logic conflict_inc;

   // Only an access in flight has an owner, so IDLE never counts as a conflict.
   assign conflict_inc = ((state == S_BUSY) || (state == S_RESP)) &&
                         ((ic_req && owner) || (dc_req && !owner));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_ic_grants <= '0;
         stat_dc_grants <= '0;
         stat_conflicts <= '0;
      end else begin
         if (grant_vld && !grant_dc) stat_ic_grants <= stat_ic_grants + 32'd1;
         if (grant_vld && grant_dc)  stat_dc_grants <= stat_dc_grants + 32'd1;
         if (conflict_inc)           stat_conflicts <= stat_conflicts + 32'd1;
      end
   end
`else
   assign stat_ic_grants = '0;
   assign stat_dc_grants = '0;
   assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LATENCY=4 instance and one LATENCY=1 instance, each with a line memory model.
module tb_mem_arbiter;

   localparam logic [127:0] LINE_AA = {16{8'hAA}};
   localparam logic [127:0] LINE_33 = {16{8'h33}};
   localparam logic [127:0] LINE_W  = 128'h1234;
   localparam logic [127:0] LINE_X  = 128'hDEAD;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // LATENCY = 4 instance
   logic         ic_req = 0, dc_req = 0, dc_write = 0;
   logic [31:0]  ic_addr = 0, dc_addr = 0;
   logic [127:0] dc_wdata = 0;
   logic         ic_ack, dc_ack, m_rd, m_wr;
   logic [127:0] ic_rdata, dc_rdata, m_wdata, m_rdata;
   logic [31:0]  m_addr, st_ic, st_dc, st_cf;
   logic [127:0] mem4 [0:15];

   // LATENCY = 1 instance
   logic         b_ic_req = 0, b_dc_req = 0, b_dc_write = 0;
   logic [31:0]  b_ic_addr = 0, b_dc_addr = 0;
   logic [127:0] b_dc_wdata = 0;
   logic         b_ic_ack, b_dc_ack, b_rd, b_wr;
   logic [127:0] b_ic_rdata, b_dc_rdata, b_wdata, b_rdata;
   logic [31:0]  b_addr, b_st_ic, b_st_dc, b_st_cf;
   logic [127:0] mem1 [0:15];

   mem_arbiter #(.WIDTH(128), .ADDR(32), .LATENCY(4)) u_dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_memread(m_rd), .mem_memwrite(m_wr),
      .mem_rdata(m_rdata),
      .stat_ic_grants(st_ic), .stat_dc_grants(st_dc), .stat_conflicts(st_cf)
   );

   mem_arbiter #(.WIDTH(128), .ADDR(32), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .ic_req(b_ic_req), .ic_addr(b_ic_addr), .ic_ack(b_ic_ack), .ic_rdata(b_ic_rdata),
      .dc_req(b_dc_req), .dc_write(b_dc_write), .dc_addr(b_dc_addr), .dc_wdata(b_dc_wdata),
      .dc_ack(b_dc_ack), .dc_rdata(b_dc_rdata),
      .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_memread(b_rd), .mem_memwrite(b_wr),
      .mem_rdata(b_rdata),
      .stat_ic_grants(b_st_ic), .stat_dc_grants(b_st_dc), .stat_conflicts(b_st_cf)
   );

   // Line memories: combinational read, write at the clock edge; contents survive reset.
   assign m_rdata = mem4[m_addr[7:4]];
   assign b_rdata = mem1[b_addr[7:4]];

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem4[i] <= '0;
         mem1[i] <= '0;
      end
      mem4[1] <= LINE_AA;
      mem4[3] <= LINE_33;
      mem1[1] <= LINE_AA;
      mem1[3] <= LINE_33;
   end

   always @(posedge clk) begin
      if (m_wr) mem4[m_addr[7:4]] <= m_wdata;
      if (b_wr) mem1[b_addr[7:4]] <= b_wdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      checks++;
      if ({ic_ack, dc_ack, m_rd, m_wr} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes: got %b required 0000", {ic_ack, dc_ack, m_rd, m_wr});
      end
      checks++;
      if (ic_rdata !== '0 || dc_rdata !== '0) begin
         errors++;
         $display("FAIL reset_rdata: got ic=%0h dc=%0h required 0", ic_rdata, dc_rdata);
      end
      checks++;
      if (m_addr !== '0 || m_wdata !== '0) begin
         errors++;
         $display("FAIL reset_mem_bus: got addr=%0h wdata=%0h required 0", m_addr, m_wdata);
      end
      checks++;
      if (st_ic !== 0 || st_dc !== 0 || st_cf !== 0) begin
         errors++;
         $display("FAIL reset_stats: got %0d %0d %0d required 0 0 0", st_ic, st_dc, st_cf);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_ic_read();
      ic_addr = 32'h10;
      ic_req  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (ic_ack !== (k == 5)) begin
            errors++;
            $display("FAIL ic_read_ack k=%0d: got %b required %b", k, ic_ack, (k == 5));
         end
         checks++;
         if (m_rd !== (k >= 1 && k <= 4) || m_wr !== 1'b0) begin
            errors++;
            $display("FAIL ic_read_strobes k=%0d: got rd=%b wr=%b required rd=%b wr=0", k, m_rd, m_wr, (k <= 4));
         end
         checks++;
         if (m_addr !== ((k <= 4) ? 32'h10 : 32'h0)) begin
            errors++;
            $display("FAIL ic_read_addr k=%0d: got %0h", k, m_addr);
         end
         if (k == 5) begin
            checks++;
            if (ic_rdata !== LINE_AA) begin
               errors++;
               $display("FAIL ic_read_data: got %0h required %0h", ic_rdata, LINE_AA);
            end
            ic_req = 1'b0;
         end
      end
   endtask

   task automatic test_dc_write_read();
      dc_addr  = 32'h20;
      dc_wdata = LINE_W;
      dc_write = 1'b1;
      dc_req   = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (m_wr !== (k == 4) || dc_ack !== (k == 5)) begin
            errors++;
            $display("FAIL dc_write k=%0d: got wr=%b ack=%b required wr=%b ack=%b", k, m_wr, dc_ack, (k == 4), (k == 5));
         end
         if (k == 5) begin
            checks++;
            if (dc_rdata !== '0) begin
               errors++;
               $display("FAIL dc_write_rdata_hold: got %0h required 0", dc_rdata);
            end
            dc_req   = 1'b0;
            dc_write = 1'b0;
         end
      end
      dc_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (dc_ack !== (k == 5) || m_wr !== 1'b0 || m_rd !== (k <= 4)) begin
            errors++;
            $display("FAIL dc_read k=%0d: got ack=%b rd=%b wr=%b", k, dc_ack, m_rd, m_wr);
         end
         if (k == 5) begin
            checks++;
            if (dc_rdata !== LINE_W) begin
               errors++;
               $display("FAIL dc_read_data: got %0h required %0h", dc_rdata, LINE_W);
            end
            dc_req = 1'b0;
         end
      end
   endtask

   task automatic test_contention();
      apply_reset();
      ic_addr = 32'h10;
      dc_addr = 32'h30;
      dc_write = 1'b0;
      ic_req = 1'b1;
      dc_req = 1'b1;
      for (int k = 1; k <= 23; k++) begin
         step();
         checks++;
         if (dc_ack !== (k == 5 || k == 17) || ic_ack !== (k == 11 || k == 23)) begin
            errors++;
            $display("FAIL contention_order k=%0d: got dc_ack=%b ic_ack=%b required %b %b",
                     k, dc_ack, ic_ack, (k == 5 || k == 17), (k == 11 || k == 23));
         end
         if (k == 5) begin
            checks++;
            if (dc_rdata !== LINE_33) begin
               errors++;
               $display("FAIL contention_dc_data: got %0h required %0h", dc_rdata, LINE_33);
            end
         end
         if (k == 11) begin
            checks++;
            if (ic_rdata !== LINE_AA) begin
               errors++;
               $display("FAIL contention_ic_data: got %0h required %0h", ic_rdata, LINE_AA);
            end
         end
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      step();
   endtask

   task automatic test_stats();
      logic [31:0] e_ic, e_dc, e_cf;
`ifdef MEM_ARBITER_STATS_EN
      e_ic = 32'd1; e_dc = 32'd1; e_cf = 32'd5;
`else
      e_ic = 32'd0; e_dc = 32'd0; e_cf = 32'd0;
`endif
      apply_reset();
      ic_addr = 32'h10;
      dc_addr = 32'h30;
      ic_req = 1'b1;
      dc_req = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 5) dc_req = 1'b0;
         if (k == 11) ic_req = 1'b0;
      end
      checks++;
      if (st_ic !== e_ic || st_dc !== e_dc) begin
         errors++;
         $display("FAIL stats_grants: got ic=%0d dc=%0d required ic=%0d dc=%0d", st_ic, st_dc, e_ic, e_dc);
      end
      checks++;
      if (st_cf !== e_cf) begin
         errors++;
         $display("FAIL stats_conflicts: got %0d required %0d", st_cf, e_cf);
      end
   endtask

   task automatic test_reset_mid_write();
      int acks = 0;
      dc_addr  = 32'h30;
      dc_wdata = LINE_X;
      dc_write = 1'b1;
      dc_req   = 1'b1;
      step();
      step();
      checks++;
      if (m_wr !== 1'b0 || m_addr !== 32'h30) begin
         errors++;
         $display("FAIL midwrite_busy2: got wr=%b addr=%0h required wr=0 addr=30", m_wr, m_addr);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({m_rd, m_wr, dc_ack, ic_ack} !== 4'b0000 || m_addr !== '0 || m_wdata !== '0 || dc_rdata !== '0) begin
         errors++;
         $display("FAIL midwrite_reset_outputs: got rd=%b wr=%b ack=%b addr=%0h wdata=%0h",
                  m_rd, m_wr, dc_ack, m_addr, m_wdata);
      end
      dc_req   = 1'b0;
      dc_write = 1'b0;
      step();
      step();
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (dc_ack) acks++;
      end
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL midwrite_no_ack: got %0d acks required 0", acks);
      end
      dc_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 5) begin
            checks++;
            if (dc_ack !== 1'b1 || dc_rdata !== LINE_33) begin
               errors++;
               $display("FAIL midwrite_readback: got ack=%b data=%0h required ack=1 data=%0h", dc_ack, dc_rdata, LINE_33);
            end
            dc_req = 1'b0;
         end
      end
      step();
   endtask

   task automatic test_latency1();
      logic [31:0] e_ic;
`ifdef MEM_ARBITER_STATS_EN
      e_ic = 32'd2;
`else
      e_ic = 32'd0;
`endif
      b_ic_addr = 32'h10;
      b_ic_req  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++;
         if (b_ic_ack !== (k == 2 || k == 5) || b_rd !== (k == 1 || k == 4) || b_wr !== 1'b0) begin
            errors++;
            $display("FAIL lat1 k=%0d: got ack=%b rd=%b wr=%b required ack=%b rd=%b wr=0",
                     k, b_ic_ack, b_rd, b_wr, (k == 2 || k == 5), (k == 1 || k == 4));
         end
         if (k == 2) begin
            checks++;
            if (b_ic_rdata !== LINE_AA) begin
               errors++;
               $display("FAIL lat1_data1: got %0h required %0h", b_ic_rdata, LINE_AA);
            end
            b_ic_addr = 32'h30;
         end
         if (k == 5) begin
            checks++;
            if (b_ic_rdata !== LINE_33) begin
               errors++;
               $display("FAIL lat1_data2: got %0h required %0h", b_ic_rdata, LINE_33);
            end
            b_ic_req = 1'b0;
         end
      end
      checks++;
      if (b_st_ic !== e_ic || b_st_dc !== 0 || b_st_cf !== 0 || b_dc_ack !== 1'b0 || b_dc_rdata !== '0) begin
         errors++;
         $display("FAIL lat1_side: got stats %0d %0d %0d dc_ack=%b", b_st_ic, b_st_dc, b_st_cf, b_dc_ack);
      end
   endtask

   initial begin
      test_reset();
      test_ic_read();
      test_dc_write_read();
      test_contention();
      test_stats();
      test_reset_mid_write();
      test_latency1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
